memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// Memory stage of the vector encryption pipeline; sits directly after the EX/MEM pipe register.
// Performs vector loads and stores against a local data memory, addressed by the integer ALU result.
// Selects the writeback data and registers it into a MEM/WB pipe register.
// Loads take two cycles; the stage stalls upstream for one cycle on every load.
// PARAMETERS
// REGI_BITS   4   integer register index width
// VECT_BITS   2   vector register index width
// MEMO_LINES  64  data memory depth in vector lines; must be a power of 2
// VECT_SIZE   8   elements per vector line
// ELEM_SIZE   8   element width in bits; also the address/integer result width
// ADDR_BITS   localparam $clog2(MEMO_LINES)
// PORTS
// clk_i             in   1                    clock
// rst_i             in   1                    asynchronous, active-low reset
// valid_i           in   1                    EX/MEM holds a live instruction
// ialu_res_i        in   ELEM_SIZE            integer result; also the memory line address
// valu_res_i        in   ELEM_SIZE*VECT_SIZE  vector result; also the store data
// enableMem_i       in   1                    instruction accesses memory
// enableReg_i       in   1                    instruction writes the register file
// flagMemRead_i     in   1                    load
// flagMemWrite_i    in   1                    store
// writeResultInt_i  in   1                    destination is an integer register
// writeResultV_i    in   1                    destination is a vector register
// intRegDest_i      in   REGI_BITS            integer destination index
// vecRegDest_i      in   VECT_BITS            vector destination index
// stall_o           out  1                    hold EX/MEM and all earlier stages this cycle (combinational)
// wb_valid_o        out  1                    MEM/WB holds a live instruction
// wb_int_we_o       out  1                    write the integer register file
// wb_vec_we_o       out  1                    write the vector register file
// wb_int_data_o     out  ELEM_SIZE            integer writeback data
// wb_vec_data_o     out  ELEM_SIZE*VECT_SIZE  vector writeback data
// wb_int_dest_o     out  REGI_BITS            integer destination index
// wb_vec_dest_o     out  VECT_BITS            vector destination index
// mem_fault_o       out  1                    registered; the instruction now in MEM/WB faulted
// BEHAVIOUR
// - Reset (rst_i=0, asynchronous): FSM goes to MS_IDLE. Every wb_* output and mem_fault_o go to 0.
//   stall_o is 0 while in reset. Memory contents are NOT reset. Reset mid-load aborts the load with no writeback.
// - req  = valid_i & enableMem_i.
// - oob  = (ialu_res_i >= MEMO_LINES).
// - bad  = req & (oob | (flagMemRead_i & flagMemWrite_i)).
// - A bad request performs no access and does not stall.
//   It registers wb_valid_o=1, both write enables 0, and mem_fault_o=1.
// - FSM MS_IDLE:
//   - On a load (req & read & !bad): issue the RAM read at this edge and assert stall_o=1 this cycle.
//     Go to MS_RD_WAIT. Register wb_valid_o=0 (bubble).
//   - On a store (req & write & !bad): mem[addr] <= valu_res_i at this edge. No stall, no register write.
//     Register wb_valid_o=1 and both write enables 0.
//   - Otherwise (ALU op, or valid_i=0): pass through in 1 cycle.
//     wb_int_data_o <= ialu_res_i, wb_vec_data_o <= valu_res_i, wb_valid_o <= valid_i.
// - FSM MS_RD_WAIT:
//   - stall_o=0. The inputs still present the same load, because upstream was held.
//   - Capture wb_vec_data_o <= RAM data and wb_valid_o <= 1. Return to MS_IDLE.
// - Write enables: wb_int_we_o <= valid & enableReg_i & writeResultInt_i.
//   wb_vec_we_o <= valid & enableReg_i & writeResultV_i. Both are 0 on bubble, store or fault.
// - Dest fields are always registered from intRegDest_i / vecRegDest_i.
// - Latency: non-load instructions take 1 cycle. A load takes 2 cycles plus 1 stall cycle.
// - Store at edge N followed by a load of the same line accepted in cycle N+1 returns the new data.
//   The RAM is write-first across cycles; there is no same-cycle read/write.
// - Address = ialu_res_i[ADDR_BITS-1:0]. It is used only when oob=0.
// STRUCTURE
// - super_pkg: typedef enum logic {MS_IDLE, MS_RD_WAIT} mem_state_t, and the line-width constant.
// - Sub-module data_memory: synchronous single-port RAM of MEMO_LINES x ELEM_SIZE*VECT_SIZE.
//   Registered read data, one write port, no reset.
// - Top level holds the FSM, the fault logic and the MEM/WB registers.
// TESTING
// 1 Store valu=64'h0123_4567_89AB_CDEF to address 5, then load address 5 into v2.
//   -> stall_o=1 for one cycle; wb_vec_data_o=64'h0123_4567_89AB_CDEF; wb_vec_we_o=1; wb_vec_dest_o=2.
// 2 ALU op with ialu_res=8'h3C, int dest r7 -> next cycle wb_int_data_o=8'h3C, wb_int_we_o=1, stall_o never high.
// 3 Load at address 8'd64 (oob) -> no stall; mem_fault_o=1; both write enables 0; memory unchanged.
// 4 Read and write both set at address 3 -> mem_fault_o=1; line 3 unchanged on readback.
// 5 Store to line 63 with data all 1s, then load line 0 (reset contents written earlier as 0).
//   -> line 0 reads 0; line 63 reads all 1s (no aliasing or wrap).
// 6 Drop rst_i low during MS_RD_WAIT.
//   -> wb_valid_o=0 and stall_o=0 immediately; after release the FSM is in MS_IDLE and there is no writeback.

Source files
------------

// File: rtl/super_pkg.sv
// Shared types and sizing for the vector encryption pipeline memory stage.
package super_pkg;

    typedef enum logic {MS_IDLE, MS_RD_WAIT} mem_state_t;

    localparam int unsigned ELEM_SIZE_DEF = 8;
    localparam int unsigned VECT_SIZE_DEF = 8;

    function automatic int unsigned lineBits(input int unsigned elemSize, input int unsigned vectSize);
        return elemSize * vectSize;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Synchronous single-port data RAM with registered read data and no reset.
module data_memory #(
    parameter  int unsigned LINES = 64,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned AW    = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             readEn,
    input  logic             writeEn,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] readData
);

    logic [WIDTH-1:0] mem [LINES];

    always_ff @(posedge clk) begin
        if (writeEn) mem[addr] <= writeData;
        if (readEn)  readData  <= mem[addr];
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: vector load/store against local RAM, fault detection, MEM/WB register.
module memory_stage import super_pkg::*; #(
    parameter int unsigned REGI_BITS  = 4,
    parameter int unsigned VECT_BITS  = 2,
    parameter int unsigned MEMO_LINES = 64,
    parameter int unsigned VECT_SIZE  = VECT_SIZE_DEF,
    parameter int unsigned ELEM_SIZE  = ELEM_SIZE_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    input  logic [ELEM_SIZE-1:0]           ialu_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
    input  logic                           enableMem_i,
    input  logic                           enableReg_i,
    input  logic                           flagMemRead_i,
    input  logic                           flagMemWrite_i,
    input  logic                           writeResultInt_i,
    input  logic                           writeResultV_i,
    input  logic [REGI_BITS-1:0]           intRegDest_i,
    input  logic [VECT_BITS-1:0]           vecRegDest_i,
    output logic                           stall_o,
    output logic                           wb_valid_o,
    output logic                           wb_int_we_o,
    output logic                           wb_vec_we_o,
    output logic [ELEM_SIZE-1:0]           wb_int_data_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] wb_vec_data_o,
    output logic [REGI_BITS-1:0]           wb_int_dest_o,
    output logic [VECT_BITS-1:0]           wb_vec_dest_o,
    output logic                           mem_fault_o
);

    localparam int unsigned ADDR_BITS = $clog2(MEMO_LINES);
    localparam int unsigned LINE_BITS = lineBits(ELEM_SIZE, VECT_SIZE);

    mem_state_t state, stateNext;

    logic                 req, oob, bad;
    logic                 ramRead, ramWrite;
    logic [LINE_BITS-1:0] ramData;
    logic [ADDR_BITS-1:0] addr;

    logic                 validNext, intWeNext, vecWeNext, faultNext;
    logic [ELEM_SIZE-1:0] intDataNext;
    logic [LINE_BITS-1:0] vecDataNext;

    // Depth is a power of two, so any set bit above the index field is out of range.
    assign oob  = (ialu_res_i >> ADDR_BITS) != '0;
    assign req  = valid_i & enableMem_i;
    assign bad  = req & (oob | (flagMemRead_i & flagMemWrite_i));
    assign addr = ialu_res_i[ADDR_BITS-1:0];

    data_memory #(
        .LINES (MEMO_LINES),
        .WIDTH (LINE_BITS)
    ) u_mem (
        .clk       (clk_i),
        .readEn    (ramRead),
        .writeEn   (ramWrite),
        .addr      (addr),
        .writeData (valu_res_i),
        .readData  (ramData)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= MS_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        stall_o     = 1'b0;
        ramRead     = 1'b0;
        ramWrite    = 1'b0;
        validNext   = valid_i;
        intWeNext   = valid_i & enableReg_i & writeResultInt_i;
        vecWeNext   = valid_i & enableReg_i & writeResultV_i;
        faultNext   = 1'b0;
        intDataNext = ialu_res_i;
        vecDataNext = valu_res_i;
        unique case (state)
            MS_IDLE: begin
                if (bad) begin
                    validNext = 1'b1;
                    intWeNext = 1'b0;
                    vecWeNext = 1'b0;
                    faultNext = 1'b1;
                end else if (req & flagMemRead_i) begin
                    // Stall is masked in reset so a held load cannot freeze upstream.
                    ramRead   = rst_i;
                    stall_o   = rst_i;
                    stateNext = MS_RD_WAIT;
                    validNext = 1'b0;
                    intWeNext = 1'b0;
                    vecWeNext = 1'b0;
                end else if (req & flagMemWrite_i) begin
                    ramWrite  = rst_i;
                    validNext = 1'b1;
                    intWeNext = 1'b0;
                    vecWeNext = 1'b0;
                end
            end
            MS_RD_WAIT: begin
                validNext   = 1'b1;
                vecDataNext = ramData;
                stateNext   = MS_IDLE;
            end
            default: stateNext = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_o    <= 1'b0;
            wb_int_we_o   <= 1'b0;
            wb_vec_we_o   <= 1'b0;
            wb_int_data_o <= '0;
            wb_vec_data_o <= '0;
            wb_int_dest_o <= '0;
            wb_vec_dest_o <= '0;
            mem_fault_o   <= 1'b0;
        end else begin
            wb_valid_o    <= validNext;
            wb_int_we_o   <= intWeNext;
            wb_vec_we_o   <= vecWeNext;
            wb_int_data_o <= intDataNext;
            wb_vec_data_o <= vecDataNext;
            wb_int_dest_o <= intRegDest_i;
            wb_vec_dest_o <= vecRegDest_i;
            mem_fault_o   <= faultNext;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage with hand-computed expectations.
module tb_memory_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, enableMem_i, enableReg_i, flagMemRead_i, flagMemWrite_i;
    logic        writeResultInt_i, writeResultV_i;
    logic [7:0]  ialu_res_i;
    logic [63:0] valu_res_i;
    logic [3:0]  intRegDest_i;
    logic [1:0]  vecRegDest_i;
    logic        stall_o, wb_valid_o, wb_int_we_o, wb_vec_we_o, mem_fault_o;
    logic [7:0]  wb_int_data_o;
    logic [63:0] wb_vec_data_o;
    logic [3:0]  wb_int_dest_o;
    logic [1:0]  wb_vec_dest_o;

    int checks = 0;
    int errors = 0;

    memory_stage #(
        .REGI_BITS  (4),
        .VECT_BITS  (2),
        .MEMO_LINES (64),
        .VECT_SIZE  (8),
        .ELEM_SIZE  (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .ialu_res_i       (ialu_res_i),
        .valu_res_i       (valu_res_i),
        .enableMem_i      (enableMem_i),
        .enableReg_i      (enableReg_i),
        .flagMemRead_i    (flagMemRead_i),
        .flagMemWrite_i   (flagMemWrite_i),
        .writeResultInt_i (writeResultInt_i),
        .writeResultV_i   (writeResultV_i),
        .intRegDest_i     (intRegDest_i),
        .vecRegDest_i     (vecRegDest_i),
        .stall_o          (stall_o),
        .wb_valid_o       (wb_valid_o),
        .wb_int_we_o      (wb_int_we_o),
        .wb_vec_we_o      (wb_vec_we_o),
        .wb_int_data_o    (wb_int_data_o),
        .wb_vec_data_o    (wb_vec_data_o),
        .wb_int_dest_o    (wb_int_dest_o),
        .wb_vec_dest_o    (wb_vec_dest_o),
        .mem_fault_o      (mem_fault_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic eMem, input logic eReg, input logic rd,
                         input logic wr, input logic wInt, input logic wVec,
                         input logic [7:0] ialu, input logic [63:0] valu,
                         input logic [3:0] iDest, input logic [1:0] vDest);
        valid_i          = v;
        enableMem_i      = eMem;
        enableReg_i      = eReg;
        flagMemRead_i    = rd;
        flagMemWrite_i   = wr;
        writeResultInt_i = wInt;
        writeResultV_i   = wVec;
        ialu_res_i       = ialu;
        valu_res_i       = valu;
        intRegDest_i     = iDest;
        vecRegDest_i     = vDest;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 64'h0, 4'h0, 2'h0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doStore(input string tag, input logic [7:0] a, input logic [63:0] d);
        drive(1, 1, 0, 0, 1, 0, 0, a, d, 4'h0, 2'h0);
        #1 check({tag, " stall"}, 64'(stall_o), 64'd0);
        tick();
        check({tag, " valid"}, 64'(wb_valid_o), 64'd1);
        check({tag, " vec_we"}, 64'(wb_vec_we_o), 64'd0);
        check({tag, " int_we"}, 64'(wb_int_we_o), 64'd0);
        check({tag, " fault"}, 64'(mem_fault_o), 64'd0);
    endtask

    task automatic doLoad(input string tag, input logic [7:0] a, input logic [1:0] vd, input logic [63:0] exp);
        drive(1, 1, 1, 1, 0, 0, 1, a, 64'h0, 4'h0, vd);
        #1 check({tag, " stall"}, 64'(stall_o), 64'd1);
        tick();
        check({tag, " bubble"}, 64'(wb_valid_o), 64'd0);
        check({tag, " stall2"}, 64'(stall_o), 64'd0);
        tick();
        check({tag, " valid"}, 64'(wb_valid_o), 64'd1);
        check({tag, " data"}, wb_vec_data_o, exp);
        check({tag, " vec_we"}, 64'(wb_vec_we_o), 64'd1);
        check({tag, " vdest"}, 64'(wb_vec_dest_o), 64'(vd));
        check({tag, " fault"}, 64'(mem_fault_o), 64'd0);
    endtask

    initial begin
        rst_i = 1'b0;
        idle();
        #12;
        check("rst valid", 64'(wb_valid_o), 64'd0);
        check("rst fault", 64'(mem_fault_o), 64'd0);
        check("rst vdata", wb_vec_data_o, 64'h0);
        check("rst stall", 64'(stall_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // store then load of the same line
        doStore("t1 st5", 8'd5, 64'h0123_4567_89AB_CDEF);
        doLoad("t1 ld5", 8'd5, 2'd2, 64'h0123_4567_89AB_CDEF);

        // plain ALU op
        drive(1, 0, 1, 0, 0, 1, 0, 8'h3C, 64'hDEAD_BEEF_0000_1111, 4'd7, 2'd0);
        #1 check("t2 stall", 64'(stall_o), 64'd0);
        tick();
        check("t2 idata", 64'(wb_int_data_o), 64'h3C);
        check("t2 int_we", 64'(wb_int_we_o), 64'd1);
        check("t2 idest", 64'(wb_int_dest_o), 64'd7);
        check("t2 vec_we", 64'(wb_vec_we_o), 64'd0);
        check("t2 valid", 64'(wb_valid_o), 64'd1);

        // out-of-range load and store at 64 (low bits alias line 0)
        doStore("t3 st0", 8'd0, 64'h0);
        drive(1, 1, 1, 1, 0, 1, 1, 8'd64, 64'h0, 4'd1, 2'd1);
        #1 check("t3 ld stall", 64'(stall_o), 64'd0);
        tick();
        check("t3 ld fault", 64'(mem_fault_o), 64'd1);
        check("t3 ld int_we", 64'(wb_int_we_o), 64'd0);
        check("t3 ld vec_we", 64'(wb_vec_we_o), 64'd0);
        check("t3 ld valid", 64'(wb_valid_o), 64'd1);
        drive(1, 1, 0, 0, 1, 0, 0, 8'd64, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 2'd0);
        #1 check("t3 st stall", 64'(stall_o), 64'd0);
        tick();
        check("t3 st fault", 64'(mem_fault_o), 64'd1);
        doLoad("t3 ld0", 8'd0, 2'd1, 64'h0);

        // read and write both set
        doStore("t4 st3", 8'd3, 64'hA5A5_5A5A_1234_8765);
        drive(1, 1, 1, 1, 1, 0, 1, 8'd3, 64'h1111_2222_3333_4444, 4'd0, 2'd3);
        #1 check("t4 stall", 64'(stall_o), 64'd0);
        tick();
        check("t4 fault", 64'(mem_fault_o), 64'd1);
        check("t4 vec_we", 64'(wb_vec_we_o), 64'd0);
        doLoad("t4 ld3", 8'd3, 2'd3, 64'hA5A5_5A5A_1234_8765);

        // top line, no wrap onto line 0
        doStore("t5 st63", 8'd63, 64'hFFFF_FFFF_FFFF_FFFF);
        doLoad("t5 ld0", 8'd0, 2'd0, 64'h0);
        doLoad("t5 ld63", 8'd63, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);

        // reset while waiting on read data
        drive(1, 1, 1, 1, 0, 0, 1, 8'd5, 64'h0, 4'h0, 2'd2);
        #1 check("t6 stall", 64'(stall_o), 64'd1);
        tick();
        rst_i = 1'b0;
        #1;
        check("t6 rst valid", 64'(wb_valid_o), 64'd0);
        check("t6 rst stall", 64'(stall_o), 64'd0);
        check("t6 rst vec_we", 64'(wb_vec_we_o), 64'd0);
        idle();
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        check("t6 no wb valid", 64'(wb_valid_o), 64'd0);
        check("t6 no wb vec_we", 64'(wb_vec_we_o), 64'd0);
        doLoad("t6 ld5", 8'd5, 2'd2, 64'h0123_4567_89AB_CDEF);

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
